spi_mode0_slave_rx: RTL and testbench

- SPI mode 0 (CPOL=0, CPHA=0) receive-only slave, directly downstream of the team's SPI mode 0 master transmitter; consumes its SCLK, CS and DO lines.
- Oversamples the SPI lines in the system clock domain and assembles MSB-first bytes.
- Buffers received bytes in a small FIFO and presents them on a valid/ready stream.
- Flags overflow and truncated frames.

---
 rtl/spi_mode0_slave_rx.sv | 156 +++++++++++++++
 tb/tb_spi_mode0_slave_rx.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mode0_slave_rx.sv
// spi_mode0_slave_rx: SPI mode 0 receive-only slave.
// Ports: sclk_i/cs_i/mosi_i in; rx_data/rx_valid/rx_ready FWFT stream;
// busy (frame active), overflow and frame_err one-cycle pulses.
module spi_mode0_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_i,
  input  logic              cs_i,
  input  logic              mosi_i,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              overflow,
  output logic              frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DATA_W);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic sclk_prev;
  logic sclk_s, cs_s, mosi_s, rise;

  state_t state, state_nx;
  logic [CW-1:0] bit_cnt, bit_cnt_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic push, ferr_nx;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_nx;
  logic [DATA_W-1:0] last_q;
  logic full, pop, wr_en, ovf_nx;

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign cs_s   = cs_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_prev & ~cs_s;
  assign busy   = ~cs_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q    <= '0;
      cs_q      <= '1;
      mosi_q    <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
      cs_q      <= {cs_q[SYNC_STAGES-2:0], cs_i};
      mosi_q    <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev <= sclk_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    push       = 1'b0;
    ferr_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!cs_s) begin
          state_nx   = SHIFT;
          bit_cnt_nx = '0;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          state_nx   = IDLE;
          bit_cnt_nx = '0;
          ferr_nx    = (bit_cnt != '0);
        end else if (rise) begin
          shreg_nx = {shreg[DATA_W-2:0], mosi_s};
          if (bit_cnt == CW'(DATA_W-1)) begin
            bit_cnt_nx = '0;
            push       = 1'b1;
          end else begin
            bit_cnt_nx = bit_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot a full FIFO needs.
  assign full   = (count == (AW+1)'(FIFO_DEPTH));
  assign pop    = rx_valid & rx_ready;
  assign wr_en  = push & (~full | pop);
  assign ovf_nx = push & full & ~pop;

  always_comb begin
    count_nx = count;
    if (wr_en && !pop) begin
      count_nx = count + 1'b1;
    end else if (pop && !wr_en) begin
      count_nx = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= shreg_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_q    <= '0;
      rx_valid  <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      count     <= count_nx;
      rx_valid  <= (count_nx != '0);
      overflow  <= ovf_nx;
      frame_err <= ferr_nx;
    end
  end

  // Empty FIFO keeps showing the last word handed out.
  assign rx_data = rx_valid ? mem[rd_ptr] : last_q;

endmodule

// File: tb/tb_spi_mode0_slave_rx.sv
// tb_spi_mode0_slave_rx: randomized bench for spi_mode0_slave_rx.
// Word-level FIFO model; outputs checked every falling clk edge.
module tb_spi_mode0_slave_rx;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int SS    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk_i = 1'b0;
  logic cs_i = 1'b1;
  logic mosi_i = 1'b0;
  logic rx_ready = 1'b0;
  logic [DW-1:0] rx_data;
  logic rx_valid, busy, overflow, frame_err;

  spi_mode0_slave_rx #(
    .DATA_W(DW),
    .FIFO_DEPTH(DEPTH),
    .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sclk_i(sclk_i),
    .cs_i(cs_i),
    .mosi_i(mosi_i),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .busy(busy),
    .overflow(overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] got[$];
  logic [DW-1:0] last_exp = '0;
  logic [DW-1:0] push_w = '0;
  logic [DW-1:0] cur = '0;
  bit busy_exp = 0;
  bit ovf_now = 0;
  bit ferr_now = 0;
  bit busy_val = 0;
  bit ferr_val = 0;
  bit rand_rdy = 0;
  bit pop_sync = 0;
  int push_cd = 0;
  int busy_cd = 0;
  int ferr_cd = 0;
  int bits = 0;
  int ovf_cnt = 0;
  int ferr_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("rx_valid", 32'(rx_valid), 32'(q.size() != 0));
    chk("busy", 32'(busy), 32'(busy_exp));
    chk("overflow", 32'(overflow), 32'(ovf_now));
    chk("frame_err", 32'(frame_err), 32'(ferr_now));
    ovf_now  = 0;
    ferr_now = 0;
    if (overflow) ovf_cnt++;
    if (frame_err) ferr_cnt++;
    if (q.size() != 0) begin
      chk("rx_data", 32'(rx_data), 32'(q[0]));
      if (rx_ready) begin
        got.push_back(rx_data);
        last_exp = q.pop_front();
      end
    end else begin
      chk("rx_data_hold", 32'(rx_data), 32'(last_exp));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (push_cd > 0) begin
      push_cd--;
      if (push_cd == 0) begin
        if (q.size() == DEPTH) ovf_now = 1;
        else q.push_back(push_w);
      end
    end
    if (busy_cd > 0) begin
      busy_cd--;
      if (busy_cd == 0) busy_exp = busy_val;
    end
    if (ferr_cd > 0) begin
      ferr_cd--;
      if (ferr_cd == 0) ferr_now = ferr_val;
    end
    if (pop_sync) begin
      if (push_cd == 1) begin
        rx_ready = 1'b1;
      end else if (push_cd == 0) begin
        rx_ready = 1'b0;
        pop_sync = 0;
      end
    end
    if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic set_cs(input bit v);
    cs_i     = v;
    busy_cd  = SS;
    busy_val = !v;
    if (v) begin
      ferr_cd  = SS + 1;
      ferr_val = (bits % DW) != 0;
    end else begin
      bits = 0;
    end
    repeat (SS + 3) tick();
  endtask

  task automatic send_bit(input bit b, input int lo, input int hi,
                          input bit sp);
    mosi_i = b;
    sclk_i = 1'b0;
    repeat (lo) tick();
    sclk_i = 1'b1;
    bits++;
    cur = {cur[DW-2:0], b};
    if (bits % DW == 0) begin
      push_w  = cur;
      push_cd = SS + 1;
      if (sp) pop_sync = 1;
    end
    repeat (hi) tick();
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int lo,
                           input int hi, input bit sp);
    for (int i = DW - 1; i >= 0; i--) begin
      send_bit(w[i], lo, hi, sp);
    end
  endtask

  task automatic end_frame();
    sclk_i = 1'b0;
    repeat (2) tick();
    set_cs(1'b1);
  endtask

  task automatic expect_got(input string nm, input logic [DW-1:0] e[$]);
    chk({nm, "_count"}, 32'(got.size()), 32'(e.size()));
    foreach (e[i]) begin
      if (i < got.size()) chk(nm, 32'(got[i]), 32'(e[i]));
    end
    got.delete();
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_rx_data", 32'(rx_data), 32'h0);
    chk("reset_rx_valid", 32'(rx_valid), 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();

    rx_ready = 1'b1;
    set_cs(1'b0);
    send_word(8'hB1, 4, 4, 0);
    end_frame();
    repeat (4) tick();
    expect_got("single", '{8'hB1});
    chk("single_ovf", 32'(ovf_cnt), 32'd0);
    chk("single_ferr", 32'(ferr_cnt), 32'd0);

    set_cs(1'b0);
    send_word(8'h00, 4, 4, 0);
    send_word(8'hFF, 4, 4, 0);
    send_word(8'h5A, 4, 4, 0);
    send_word(8'hA5, 4, 4, 0);
    end_frame();
    repeat (4) tick();
    expect_got("multi", '{8'h00, 8'hFF, 8'h5A, 8'hA5});
    chk("multi_ferr", 32'(ferr_cnt), 32'd0);

    rx_ready = 1'b0;
    set_cs(1'b0);
    for (int i = 1; i <= 5; i++) send_word(8'(i), 4, 4, 0);
    end_frame();
    chk("ovf_pulses", 32'(ovf_cnt), 32'd1);
    chk("ovf_no_pop", 32'(got.size()), 32'd0);
    rx_ready = 1'b1;
    repeat (8) tick();
    expect_got("ovf_drain", '{8'h01, 8'h02, 8'h03, 8'h04});
    ovf_cnt = 0;

    rx_ready = 1'b0;
    set_cs(1'b0);
    send_word(8'h11, 3, 3, 0);
    send_word(8'h22, 3, 3, 0);
    send_word(8'h33, 3, 3, 0);
    send_word(8'h44, 3, 3, 0);
    send_word(8'h55, 3, 3, 1);
    end_frame();
    chk("fullpop_ovf", 32'(ovf_cnt), 32'd0);
    rx_ready = 1'b1;
    repeat (8) tick();
    expect_got("fullpop", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});

    set_cs(1'b0);
    send_bit(1, 4, 4, 0);
    send_bit(0, 4, 4, 0);
    send_bit(1, 4, 4, 0);
    send_bit(1, 4, 4, 0);
    send_bit(0, 4, 4, 0);
    end_frame();
    chk("trunc_ferr", 32'(ferr_cnt), 32'd1);
    chk("trunc_nopush", 32'(got.size()), 32'd0);
    set_cs(1'b0);
    send_word(8'h3C, 4, 4, 0);
    end_frame();
    repeat (4) tick();
    expect_got("after_trunc", '{8'h3C});
    chk("after_trunc_ferr", 32'(ferr_cnt), 32'd1);
    ferr_cnt = 0;

    rx_ready = 1'b0;
    set_cs(1'b0);
    send_word(8'hAA, 4, 4, 0);
    send_word(8'hBB, 4, 4, 0);
    send_bit(1, 4, 4, 0);
    send_bit(1, 4, 4, 0);
    send_bit(0, 4, 4, 0);
    chk("pre_reset_valid", 32'(rx_valid), 32'd1);
    rst_n    = 1'b0;
    cs_i     = 1'b1;
    sclk_i   = 1'b0;
    mosi_i   = 1'b0;
    q.delete();
    push_cd  = 0;
    busy_cd  = 0;
    ferr_cd  = 0;
    busy_exp = 0;
    last_exp = '0;
    bits     = 0;
    #1;
    chk("rst_valid_now", 32'(rx_valid), 32'd0);
    chk("rst_data_now", 32'(rx_data), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    rx_ready = 1'b1;
    set_cs(1'b0);
    send_word(8'hC3, 4, 4, 0);
    end_frame();
    repeat (4) tick();
    expect_got("after_reset", '{8'hC3});
    chk("after_reset_ferr", 32'(ferr_cnt), 32'd0);

    rand_rdy = 1;
    for (int f = 0; f < 20; f++) begin
      int n, lo, hi;
      n  = $urandom_range(1, 3);
      lo = $urandom_range(2, 5);
      hi = $urandom_range(2, 5);
      set_cs(1'b0);
      for (int w = 0; w < n; w++) begin
        send_word(8'($urandom_range(0, 255)), lo, hi, 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = $urandom_range(1, DW - 1);
        for (int b = 0; b < k; b++) begin
          send_bit(1'($urandom_range(0, 1)), lo, hi, 0);
        end
      end
      end_frame();
    end
    rand_rdy = 0;
    rx_ready = 1'b1;
    repeat (10) tick();
    chk("rand_drained", 32'(rx_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
